// File: rtl/gf_inv_checker.sv
// gf_inv_checker: bit-serial GF(2^m) multiply of a by its inverse
// with a product==1 self-check and saturating pass/fail counters.
module gf_inv_checker #(
  parameter int         m     = 7,
  parameter logic [m:0] F     = 8'b10111111,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [m-1:0]     in_a,
  input  logic [m-1:0]     in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [m-1:0]     out_prod,
  output logic             out_ok,
  output logic             out_skip,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy
);

  localparam int KW = (m > 1) ? $clog2(m) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(m - 1);
  localparam logic [m-1:0] ONE = m'(1);
  localparam logic [m-1:0] RED = F[m-1:0];

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [m-1:0]  a_reg;
  logic [m-1:0]  b_reg;
  logic [m-1:0]  acc;
  logic [m-1:0]  acc_t;
  logic [m-1:0]  acc_nxt;
  logic [KW-1:0] k;
  logic          accept;
  logic          hs;
  logic          last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign last      = (k == K_LAST);

  // State register; rst wins over every handshake
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept -> m multiply steps -> hold until taken
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = MUL;
      MUL:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One MSB-first step: acc*x mod F, then add a if b bit set
  always_comb begin
    acc_t = {acc[m-2:0], 1'b0};
    if (acc[m-1]) acc_t = acc_t ^ RED;
    acc_nxt = acc_t;
    if (b_reg[m-1]) acc_nxt = acc_t ^ a_reg;
  end

  // Operand capture, multiply iteration and result registers;
  // b_reg shifts left so its MSB is always the bit for step k
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      k        <= '0;
      out_prod <= '0;
      out_ok   <= 1'b0;
      out_skip <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_inv;
      acc   <= '0;
      k     <= '0;
    end else if (state == MUL) begin
      acc   <= acc_nxt;
      b_reg <= {b_reg[m-2:0], 1'b0};
      k     <= k + 1'b1;
      if (last) begin
        out_prod <= acc_nxt;
        out_ok   <= (acc_nxt == ONE) && (a_reg != '0);
        out_skip <= (a_reg == '0);
      end
    end
  end

  // Saturating counters, advanced only on the result handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (hs) begin
      if (out_ok && (pass_cnt != '1))
        pass_cnt <= pass_cnt + 1'b1;
      if (!out_ok && !out_skip && (fail_cnt != '1))
        fail_cnt <= fail_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gf_inv_checker.sv
// tb_gf_inv_checker: directed scoreboard bench for gf_inv_checker
// with an LSB-first reference multiplier.
module tb_gf_inv_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_a;
  logic [6:0]  in_inv;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_prod;
  logic        out_ok;
  logic        out_skip;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic        busy;

  gf_inv_checker dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_ok(out_ok),
    .out_skip(out_skip),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [6:0] prod;
    logic       ok;
    logic       skip;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_pass = 0;
  int   exp_fail = 0;
  logic [6:0] pa [10];
  logic [6:0] pb [10];

  function automatic logic [6:0] gmul(
    input logic [6:0] a, input logic [6:0] b);
    logic [7:0] aa;
    logic [6:0] r;
    aa = {1'b0, a};
    r  = '0;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) r = r ^ aa[6:0];
      aa = aa << 1;
      if (aa[7]) aa = aa ^ 8'hBF;
    end
    return r;
  endfunction

  function automatic logic [6:0] ginv(input logic [6:0] a);
    for (int b = 1; b < 128; b++)
      if (gmul(a, 7'(b)) == 7'h01) return 7'(b);
    return 7'h00;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] a,
                          input logic [6:0] b);
    exp_t e;
    e.prod = gmul(a, b);
    e.ok   = (e.prod == 7'h01) && (a != 7'h00);
    e.skip = (a == 7'h00);
    sb.push_back(e);
  endtask

  task automatic apply_hs();
    if (cur.ok) exp_pass++;
    else if (!cur.skip) exp_fail++;
  endtask

  task automatic check_result();
    chk("sb_level", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("out_prod", 32'(out_prod), 32'(cur.prod));
      chk("out_ok", 32'(out_ok), 32'(cur.ok));
      chk("out_skip", 32'(out_skip), 32'(cur.skip));
    end
  endtask

  task automatic do_accept(input logic [6:0] a,
                           input logic [6:0] b);
    int n = 0;
    in_a = a;
    in_inv = b;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 40), 1);
    push_exp(a, b);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 7'($urandom);
    in_inv = 7'($urandom);
  endtask

  task automatic wait_valid(input int lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    apply_hs();
    chk("valid_drop", 32'(out_valid), 0);
    chk("ready_back", 32'(in_ready), 1);
    chk("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    chk("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
  endtask

  initial begin
    int idx;
    int got;
    int prev;
    logic seen;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_inv = '0;
    for (int i = 0; i < 10; i++) begin
      pa[i] = (i == 4) ? 7'h00 : 7'($urandom_range(1, 127));
      pb[i] = (i % 2 == 0) ? ginv(pa[i]) : 7'($urandom);
    end
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_prod", 32'(out_prod), 0);
    chk("rst_out_ok", 32'(out_ok), 0);
    chk("rst_out_skip", 32'(out_skip), 0);
    chk("rst_pass", 32'(pass_cnt), 0);
    chk("rst_fail", 32'(fail_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    // x * x^-1 = 1
    do_accept(7'h02, 7'h5F);
    wait_valid(7);
    check_result();
    handshake();

    // x^6 * x = x^7 reduced
    do_accept(7'h40, 7'h02);
    wait_valid(7);
    check_result();
    chk("x7_prod", 32'(out_prod), 32'h3F);
    handshake();

    // zero operand is skipped
    do_accept(7'h00, 7'h55);
    wait_valid(7);
    check_result();
    handshake();

    // output stall with ignored in_valid pulses
    do_accept(7'h01, 7'h01);
    wait_valid(7);
    check_result();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_a = 7'($urandom);
      in_inv = 7'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_prod", 32'(out_prod), 32'h01);
      chk("hold_ok", 32'(out_ok), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_pass", 32'(pass_cnt), 32'(exp_pass));
    end
    in_valid = 1'b0;
    handshake();

    // reset in the third multiply cycle
    do_accept(7'h03, ginv(7'h03));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_pass = 0;
    exp_fail = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_pass", 32'(pass_cnt), 0);
    chk("abort_fail", 32'(fail_cnt), 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort_no_valid", 32'(seen), 0);
    do_accept(7'h02, 7'h5F);
    wait_valid(7);
    check_result();
    handshake();

    // back-to-back stream, both handshakes tied high
    idx = 0;
    got = 0;
    prev = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && got < 10; c++) begin
      if (in_ready) begin
        if (idx < 10) begin
          in_a = pa[idx];
          in_inv = pb[idx];
          push_exp(pa[idx], pb[idx]);
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        in_a = 7'($urandom);
        in_inv = 7'($urandom);
      end
      if (out_valid) begin
        chk("b2b_pass", 32'(pass_cnt), 32'(exp_pass));
        chk("b2b_fail", 32'(fail_cnt), 32'(exp_fail));
        check_result();
        apply_hs();
        if (got > 0) chk("b2b_ii", 32'(cyc - prev), 9);
        prev = cyc;
        got++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 32'(got), 10);
    @(negedge clk);
    chk("b2b_pass_end", 32'(pass_cnt), 32'(exp_pass));
    chk("b2b_fail_end", 32'(fail_cnt), 32'(exp_fail));
    chk("sb_drain", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gf_inv_checker.md
# gf_inv_checker

Bit-serial GF(2^m) multiplier and self-check stage that sits directly downstream of the Euclidean inversion datapath. It is fed the original operand and the inverse held in U after the 2m-iteration run. It computes a·a⁻¹ mod F(x) over m clock cycles and reports whether the product equals 1. It also keeps saturating pass/fail counters for on-chip verification of the inverter.

## Interface
Parameters:
- m, 7, field degree
- F, 8'b10111111, irreducible polynomial x^7+x^5+x^4+x^3+x^2+x+1 including the x^m term. F[m-1:0] is the x^m mod F(x) constant, 0111111.
- CNT_W, 16, width of the pass and fail counters

Ports:
- clk, in, 1, single clock; all state updates on its rising edge
- rst, in, 1, synchronous, active-high reset
- in_valid, in, 1, operand pair valid
- in_ready, out, 1, block can accept a pair; high only in IDLE
- in_a, in, m, original operand a
- in_inv, in, m, candidate inverse from the inversion datapath
- out_valid, out, 1, result valid
- out_ready, in, 1, consumer accepts the result
- out_prod, out, m, a·inv mod F(x)
- out_ok, out, 1, out_prod == 1 and a != 0
- out_skip, out, 1, a == 0; no inverse exists, so no pass/fail is recorded
- pass_cnt, out, CNT_W, number of accepted results with out_ok = 1
- fail_cnt, out, CNT_W, number of accepted results with out_ok = 0 and out_skip = 0
- busy, out, 1, state != IDLE

## Operation
- FSM has three states: IDLE, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a_reg = in_a and b_reg = in_inv, clear acc, set k = 0, and go to MUL.
- MUL, one step per cycle, processing b_reg MSB first:
  - t = {acc[m-2:0],1'b0} ^ (acc[m-1] ? F[m-1:0] : 0)
  - acc <= t ^ (b_reg[m-1-k] ? a_reg : 0)
  - k increments each step.
  - After the step with k == m-1, go to DONE and register out_prod = final acc, plus out_ok and out_skip.
- DONE:
  - out_valid = 1. Outputs are held stable until out_valid & out_ready.
  - On that handshake:
    - pass_cnt increments if out_ok.
    - fail_cnt increments if !out_ok & !out_skip.
    - State returns to IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap.
- out_ok and out_skip are mutually exclusive.
- The inputs in_a and in_inv are sampled only on the accept edge. Changes to them afterwards have no effect.
- Reset values:
  - state = IDLE, so in_ready = 1 and busy = 0.
  - out_valid = 0, out_prod = 0, out_ok = 0, out_skip = 0.
  - pass_cnt = 0, fail_cnt = 0, acc = 0, k = 0.
- rst in any state, including mid-MUL or DONE with out_valid high: the next edge aborts the operation with no counter update and no out_valid pulse. rst has priority over every handshake.
- in_valid while not IDLE is ignored. The upstream stage holds the pair until in_ready.

## Timing
- Accept edge is E0. MUL steps occur on E1..Em. out_valid is high from the cycle after Em, so latency from accept to out_valid is m cycles (7).
- out_ready sampled high on the first DONE cycle returns the block to IDLE on the next edge. in_ready is high in the following cycle.
- Minimum initiation interval is m+2 cycles (9). There is no overlap between results.
- out_ready is ignored outside DONE. in_ready and out_valid are never both high.
- Counters update on the output handshake edge. The new value is visible in the cycle after that edge.

## Test plan
- Reset, then in_a=0x02, in_inv=0x5F (x⁻¹) -> out_valid 7 cycles after accept, out_prod=0x01, out_ok=1, pass_cnt=1.
- in_a=0x40, in_inv=0x02 -> out_prod=0x3F (x^7 reduction), out_ok=0, fail_cnt=1.
- in_a=0x00, in_inv=0x55 -> out_prod=0x00, out_skip=1, out_ok=0, both counters unchanged.
- in_a=0x01, in_inv=0x01 with out_ready held low 5 cycles -> out_valid, out_prod=0x01 and out_ok stable throughout; in_ready=0; in_valid pulses meanwhile are ignored; pass_cnt increments once only on the handshake edge.
- rst asserted for 1 cycle at the 3rd MUL cycle -> state IDLE, no out_valid, counters 0. A following pair (0x02, 0x5F) then completes normally with latency 7.
- 10 back-to-back pairs with in_valid and out_ready tied high -> one result every 9 cycles; counters match a golden model (a·b mod F(x)).
